// File: rtl/masked_sbox_pkg.sv
// Shared constants and types for the masked AES S-box chain front end.
`timescale 1ns/1ps
package masked_sbox_pkg;

   localparam int DATA_W      = 12;
   localparam int RAN_W       = 14;
   localparam int LFSR_W      = 64;
   localparam int WARMUP_CYC  = 16;
   localparam int RND_W       = DATA_W + RAN_W;
   localparam int STEP_SHIFTS = 32;
   localparam int WARM_CNT_W  = $clog2(WARMUP_CYC);

   // Taps for x^64+x^63+x^61+x^60+1 on a left-shifting Fibonacci register.
   localparam logic [LFSR_W-1:0] LFSR_TAPS     = 64'hD800_0000_0000_0000;
   localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h1;

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      SEED     = 2'd1,
      WARMUP   = 2'd2,
      RUN      = 2'd3
   } prng_state_e;

   // An all-zero state would lock the LFSR, so it is never loaded.
   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
      return (s == '0) ? ZERO_SEED_SUB : s;
   endfunction

endpackage

// File: rtl/masked_prng_lfsr.sv
// 64-bit Fibonacci LFSR, 32 single-bit shifts per step; rnd is the low
// 26 bits of the state that the next step will produce.
`timescale 1ns/1ps
module masked_prng_lfsr
   import masked_sbox_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [RND_W-1:0]  rnd
);

   logic [LFSR_W-1:0] state_reg;
   logic [LFSR_W-1:0] state_next;
   logic [LFSR_W-1:0] chain [0:STEP_SHIFTS];

   assign chain[0] = state_reg;

   generate
      for (genvar gi = 0; gi < STEP_SHIFTS; gi++) begin : g_shift
         assign chain[gi+1] = {chain[gi][LFSR_W-2:0], ^(chain[gi] & LFSR_TAPS)};
      end
   endgenerate

   assign state_next = chain[STEP_SHIFTS];
   assign rnd        = state_next[RND_W-1:0];

   // Seed load wins over advance so a reseed always restarts the sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ZERO_SEED_SUB;
      end else if (load) begin
         state_reg <= seed_fix(seed);
      end else if (advance) begin
         state_reg <= state_next;
      end
   end

endmodule

// File: rtl/masked_share_encoder.sv
// Splits unmasked words into two Boolean shares plus fresh randomness.
// Build option PRNG_FREE_RUN_EN: PRNG steps every RUN cycle instead of per accept.
`timescale 1ns/1ps
module masked_share_encoder
   import masked_sbox_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_valid,
   input  logic [LFSR_W-1:0] seed_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] share0,
   output logic [DATA_W-1:0] share1,
   output logic [RAN_W-1:0]  ran,
   output logic              prng_ready
);

   prng_state_e           state_reg;
   logic [WARM_CNT_W-1:0] warm_cnt_reg;
   logic                  prng_ready_reg;
   logic                  out_valid_reg;
   logic [DATA_W-1:0]     share0_reg;
   logic [DATA_W-1:0]     share1_reg;
   logic [RAN_W-1:0]      ran_reg;

   logic                  accept;
   logic                  lfsr_advance;
   logic [RND_W-1:0]      rnd;
   logic [DATA_W-1:0]     mask;

   assign in_ready = (state_reg == RUN) && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;
   assign mask     = rnd[DATA_W-1:0];

`ifdef PRNG_FREE_RUN_EN
   assign lfsr_advance = (state_reg == WARMUP) || (state_reg == RUN);
`else
   assign lfsr_advance = (state_reg == WARMUP) || accept;
`endif

   masked_prng_lfsr u_prng (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (seed_valid),
      .seed    (seed_data),
      .advance (lfsr_advance),
      .rnd     (rnd)
   );

   // A seed pulse restarts sequencing from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= UNSEEDED;
         warm_cnt_reg   <= '0;
         prng_ready_reg <= 1'b0;
      end else if (seed_valid) begin
         state_reg      <= SEED;
         warm_cnt_reg   <= '0;
         prng_ready_reg <= 1'b0;
      end else begin
         case (state_reg)
            SEED: begin
               state_reg    <= WARMUP;
               warm_cnt_reg <= '0;
            end
            WARMUP: begin
               warm_cnt_reg <= warm_cnt_reg + 1'b1;
               if (warm_cnt_reg == WARM_CNT_W'(WARMUP_CYC - 1)) begin
                  state_reg      <= RUN;
                  prng_ready_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Shares leave straight from flops; in_data only ever meets a fresh mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         share0_reg    <= '0;
         share1_reg    <= '0;
         ran_reg       <= '0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         share0_reg    <= in_data ^ mask;
         share1_reg    <= mask;
         ran_reg       <= rnd[RND_W-1:DATA_W];
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid  = out_valid_reg;
   assign share0     = share0_reg;
   assign share1     = share1_reg;
   assign ran        = ran_reg;
   assign prng_ready = prng_ready_reg;

endmodule
